// File: rtl/cr_kme_fifo_unpacker.sv
// cr_kme_fifo_unpacker
//   Read side of the KME show-ahead FIFO. Pops DATA_SIZE-bit words with the
//   FIFO valid/ack handshake and streams each one as NBEATS narrow beats,
//   LSB beat first, on a valid/ready interface toward the key-load datapath.
//   When downstream never stalls, the next word is popped in the same cycle
//   as the last beat of the current one, so the stream has no bubbles.
//
//   Optional feature macro: CR_KME_FIFO_UNPACK_CNT_EN
//     defined   -> word_cnt is a saturating 32-bit count of popped words
//     undefined -> word_cnt is tied to zero and no counter flops exist
module cr_kme_fifo_unpacker #(
  parameter int DATA_SIZE = 128,
  parameter int OUT_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] fifo_out,
  input  logic                 fifo_out_valid,
  output logic                 fifo_out_ack,
  input  logic                 flush,
  output logic [OUT_SIZE-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [31:0]          word_cnt
);

  localparam int NBEATS = DATA_SIZE / OUT_SIZE;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

  // Held word viewed as an array of beats so beat selection is a plain index.
  logic [NBEATS-1:0][OUT_SIZE-1:0] hold_q;
  logic                            hold_vld_q;
  logic [BCW-1:0]                  beat_q;

  logic beat_xfer;
  logic last_xfer;
  logic ack;

  // Pop when the FIFO has a word and the holding register is free or
  // drains its final beat this cycle; never pop during reset or flush.
  always_comb begin
    beat_xfer = hold_vld_q & out_ready;
    last_xfer = beat_xfer & (beat_q == LAST_BEAT);
    ack       = fifo_out_valid & ~flush & ~rst & (~hold_vld_q | last_xfer);
  end

  assign fifo_out_ack = ack;

  // Holding register and beat index; flush outranks both pop and transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      beat_q     <= '0;
    end else if (flush) begin
      hold_vld_q <= 1'b0;
      beat_q     <= '0;
    end else if (ack) begin
      hold_q     <= fifo_out;
      hold_vld_q <= 1'b1;
      beat_q     <= '0;
    end else if (beat_xfer) begin
      if (beat_q == LAST_BEAT) hold_vld_q <= 1'b0;
      else                     beat_q     <= beat_q + 1'b1;
    end
  end

  // Output view of the held word; sop/eop are gated so they stay low when idle.
  always_comb begin
    out_valid = hold_vld_q;
    out_data  = hold_q[beat_q];
    out_sop   = hold_vld_q & (beat_q == '0);
    out_eop   = hold_vld_q & (beat_q == LAST_BEAT);
  end

`ifdef CR_KME_FIFO_UNPACK_CNT_EN
  logic [31:0] word_cnt_q;

  // Count every pop, sticking at all-ones; flush leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            word_cnt_q <= '0;
    else if (ack && (word_cnt_q != '1)) word_cnt_q <= word_cnt_q + 32'd1;
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = 32'h0;
`endif

endmodule
